usb_rx: RTL and testbench
=========================

Name: usb_rx

Overview:
- Full-speed USB receiver: the counterpart of the USB transmitter on the same D+/D- pair.
- Recovers bit timing from the synchronized D+/D- lines, then NRZI-decodes and removes stuffed bits.
- Detects SYNC, decodes and validates the PID, then deserializes payload bytes LSB-first.
- Writes data-packet payload (CRC16 stripped) into the shared packet buffer, and reports packet type, completion and errors to the protocol controller.

Parameters:
- CLKS_PER_BIT, 4, system clocks per USB bit (48 MHz clk / 12 Mbps); must be even and at least 4.
- MAX_PAYLOAD, 64, largest data payload in bytes accepted before overflow error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- dplus_in  input  1  raw D+ line, asynchronous to clk
- dminus_in  input  1  raw D- line, asynchronous to clk
- buffer_occupancy  input  7  current packet-buffer byte count
- rx_packet  output  3  decoded PID: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6 IN, 7 OUT
- rx_data_ready  output  1  one-cycle pulse: packet ended with a valid EOP and no error
- rx_transfer_active  output  1  high from SYNC detect until the packet ends (EOP or error)
- rx_error  output  1  sticky error flag; cleared at the next SYNC detect
- flush  output  1  one-cycle pulse clearing the buffer when a DATA PID is accepted
- store_rx_packet_data  output  1  one-cycle write strobe into the buffer
- rx_packet_data  output  8  byte qualified by store_rx_packet_data

Behaviour:
- Reset: all outputs 0.
  - State goes to IDLE.
  - NRZI previous level is set to J (D+=1, D-=0).
  - Byte pipeline is emptied.
  - Reset mid-packet drops the packet silently, with no error and no ready pulse.
- Input sync: two flops per line. Line states: J=10, K=01, SE0=00; 11 is treated as SE0-invalid and raises an error.
- Bit timing:
  - The counter resets on every change of the synchronized line state.
  - The line is sampled when the counter reaches CLKS_PER_BIT/2, then once every CLKS_PER_BIT while there is no transition.
- NRZI: a sampled level equal to the previous level decodes as 1; a different level decodes as 0.
- Unstuffing: after six consecutive decoded 1s, the next bit is discarded. If that discarded bit is a 1, the block raises an error (stuff error).
- FSM states: IDLE, SYNC, PID, TOKEN, DATA, HS_EOP, EOP, ERR_WAIT.
  - IDLE -> SYNC on the first K sample. rx_transfer_active rises and rx_error clears.
  - SYNC: expects bits 0000000 then 1 (the K-J pattern ending in KK). Any other pattern is an error.
  - PID: 8 bits, low nibble must equal the bitwise complement of the high nibble, else error. An unknown PID (including SETUP/SOF) is also an error.
    - DATA0/DATA1 -> DATA, with a flush pulse.
    - ACK/NAK/STALL -> HS_EOP.
    - IN/OUT -> TOKEN.
    - rx_packet is loaded when the PID is accepted and holds until the next PID is accepted.
  - TOKEN: exactly 2 bytes (address/endpoint/CRC5), not stored and CRC not checked, then EOP. SE0 earlier or later than that is an error.
  - DATA: two-byte holding pipeline.
    - When a third byte completes, the oldest held byte is written (store pulse, 1 cycle after that byte's last bit).
    - At EOP the two held bytes (CRC16) are discarded and CRC16 is not checked.
    - Fewer than 2 bytes before EOP is an error.
    - SE0 arriving with a partial byte (1-7 bits) is an error.
    - A store attempted with buffer_occupancy >= MAX_PAYLOAD is suppressed and raises an error.
  - HS_EOP: the next event must be SE0 at a byte boundary, else error.
  - EOP: requires SE0 for 2 samples followed by a J sample.
    - The cycle after the J sample: rx_data_ready pulses, rx_transfer_active falls, and the FSM returns to IDLE.
    - An SE0 lasting more than 3 samples, or a K after SE0, is an error.
  - Any error: rx_error is set that cycle, rx_transfer_active falls, no further stores or ready pulse occur, and the FSM enters ERR_WAIT.
  - ERR_WAIT: returns to IDLE after 8 consecutive J samples (bus idle). rx_error stays set.
- Simultaneous events:
  - A store and an error on the same byte: the error wins and no store happens.
  - flush and store never coincide.

Test Plan:
- Reset then idle J for 20 bits: all outputs stay 0 and rx_packet=0.
- SYNC, ACK PID 0xD2, EOP (SE0 x2, J): rx_packet=3, one rx_data_ready pulse, no stores, and rx_transfer_active high exactly from SYNC detect to the cycle after the J sample.
- SYNC, DATA1 PID 0x4B, payload 0x01 0xFF 0x7E, CRC 0xAA 0x55, EOP: flush pulses once, then exactly 3 stores carrying 0x01, 0xFF, 0x7E in order (0xFF is sent with its stuffed bit), rx_packet=2, one rx_data_ready pulse.
- SYNC, OUT PID 0xE1, 2 token bytes, EOP: rx_packet=7, rx_data_ready pulses, no store and no flush. Repeat with 3 token bytes: rx_error=1 and no ready pulse.
- Errors, each checked separately:
  - PID 0xD3 (nibble mismatch) -> rx_error=1, FSM waits for idle.
  - Seven consecutive 1s on the line (stuff error) -> rx_error=1.
  - buffer_occupancy=64 at the first store -> no store and rx_error=1.
  - After the error, a fresh valid ACK packet clears rx_error at SYNC and passes.
- Assert rst during payload byte 2 of a DATA0 packet: outputs return to 0 the next cycle, with no error and no ready pulse. A following valid NAK (0x5A) is received correctly (rx_packet=4).

Source files
------------

// File: rtl/usb_rx.sv
// usb_rx: full-speed USB receiver front end and packet decoder.
//
// This module recovers bit timing from the raw D+/D- pair. It then NRZI-decodes
// the line and removes stuffed bits. After that it finds SYNC, checks the PID
// and deserializes bytes LSB-first.
//
// Data-packet payload goes into the shared packet buffer. The two trailing
// CRC16 bytes are held back and then dropped.
//
// Ports:
//   clk                  system clock (CLKS_PER_BIT clocks per USB bit)
//   rst                  synchronous active-high reset
//   dplus_in/dminus_in   raw bus lines, asynchronous to clk
//   buffer_occupancy     current packet-buffer byte count
//   rx_packet            last accepted PID (1 DATA0, 2 DATA1, 3 ACK, 4 NAK,
//                        5 STALL, 6 IN, 7 OUT, 0 none)
//   rx_data_ready        one-cycle pulse: packet ended cleanly
//   rx_transfer_active   high from SYNC detect to end of packet
//   rx_error             sticky error flag, cleared at the next SYNC
//   flush                one-cycle buffer clear on DATA PID accept
//   store_rx_packet_data one-cycle buffer write strobe
//   rx_packet_data       byte qualified by store_rx_packet_data
module usb_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       flush,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data
);

    localparam int unsigned   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    MAX_OCC = 7'(MAX_PAYLOAD);

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        TOKEN,
        DATA,
        HS_EOP,
        EOP,
        ERR_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and bit-timing recovery
    // ------------------------------------------------------------------
    logic          dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q;
    logic [1:0]    ls_sync;
    logic [1:0]    ls_q;
    logic [CW-1:0] cnt_q, cnt_d;

    assign ls_sync = {dp_sync_q, dm_sync_q};

    // The phase counter restarts on every line transition. The sample point
    // therefore sits half a bit after the most recent edge.
    always_comb begin
        if (ls_sync != ls_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            ls_q      <= LS_J;
            cnt_q     <= '0;
        end else begin
            dp_meta_q <= dplus_in;
            dp_sync_q <= dp_meta_q;
            dm_meta_q <= dminus_in;
            dm_sync_q <= dm_meta_q;
            ls_q      <= ls_sync;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample classification, NRZI decode, unstuffing
    // ------------------------------------------------------------------
    state_t     state_q;
    logic       prev_lvl_q;
    logic [2:0] ones_q;
    logic [2:0] bitcnt_q;
    logic [7:0] sr_q;
    logic [1:0] bytecnt_q;
    logic [1:0] held_q;
    logic [7:0] hold0_q, hold1_q;
    logic [1:0] se0cnt_q;
    logic [2:0] jcnt_q;

    logic [2:0] pkt_q;
    logic       ready_q, active_q, err_q, flush_q, store_q;
    logic [7:0] data_q;

    logic       samp, is_j, is_k, is_se0, is_inv, is_jk;
    logic       nrzi_bit, stuff_slot, bit_valid, stuff_err;
    logic       byte_done, store_try, pid_ok, err_ev;
    logic [7:0] new_byte;
    logic [2:0] pid_dec;

    function automatic logic [2:0] pid_code(input logic [3:0] p);
        case (p)
            4'b0011: pid_code = 3'd1;  // DATA0
            4'b1011: pid_code = 3'd2;  // DATA1
            4'b0010: pid_code = 3'd3;  // ACK
            4'b1010: pid_code = 3'd4;  // NAK
            4'b1110: pid_code = 3'd5;  // STALL
            4'b1001: pid_code = 3'd6;  // IN
            4'b0001: pid_code = 3'd7;  // OUT
            default: pid_code = 3'd0;  // SETUP, SOF, reserved
        endcase
    endfunction

    assign samp       = (cnt_q == HALF);
    assign is_j       = (ls_q == LS_J);
    assign is_k       = (ls_q == LS_K);
    assign is_se0     = (ls_q == LS_SE0);
    assign is_inv     = (ls_q == 2'b11);
    assign is_jk      = is_j | is_k;
    assign nrzi_bit   = (ls_q[1] == prev_lvl_q);
    assign stuff_slot = (ones_q == 3'd6);
    assign bit_valid  = samp & is_jk & ~stuff_slot;
    assign stuff_err  = samp & is_jk & stuff_slot & nrzi_bit;
    assign byte_done  = bit_valid & (bitcnt_q == 3'd7);
    assign new_byte   = {nrzi_bit, sr_q[7:1]};
    assign pid_dec    = pid_code(new_byte[3:0]);
    assign pid_ok     = (new_byte[3:0] == ~new_byte[7:4]) && (pid_dec != 3'd0);
    assign store_try  = (state_q == DATA) & byte_done & (held_q == 2'd2);

    // A single error condition for the current sample. It takes priority over
    // every state action, so a byte that errors is never stored.
    always_comb begin
        err_ev = 1'b0;
        if (samp && state_q != IDLE && state_q != ERR_WAIT) begin
            if (is_inv || stuff_err) begin
                err_ev = 1'b1;
            end else begin
                case (state_q)
                    SYNC: begin
                        // seven 0s, then a final 1
                        if (is_se0 || (bit_valid && (nrzi_bit != (bitcnt_q == 3'd7)))) begin
                            err_ev = 1'b1;
                        end
                    end
                    PID: begin
                        if (is_se0 || (byte_done && !pid_ok)) begin
                            err_ev = 1'b1;
                        end
                    end
                    TOKEN: begin
                        if (is_se0) begin
                            err_ev = (bytecnt_q != 2'd2) || (bitcnt_q != 3'd0);
                        end else if (bit_valid && bytecnt_q == 2'd2) begin
                            err_ev = 1'b1;
                        end
                    end
                    DATA: begin
                        if (is_se0) begin
                            err_ev = (held_q != 2'd2) || (bitcnt_q != 3'd0);
                        end else if (store_try && buffer_occupancy >= MAX_OCC) begin
                            err_ev = 1'b1;
                        end
                    end
                    HS_EOP: begin
                        if (is_se0) begin
                            err_ev = (bitcnt_q != 3'd0);
                        end else if (bit_valid) begin
                            err_ev = 1'b1;
                        end
                    end
                    EOP: begin
                        if (is_k || (is_se0 && se0cnt_q == 2'd3) || (is_j && se0cnt_q < 2'd2)) begin
                            err_ev = 1'b1;
                        end
                    end
                    default: err_ev = 1'b0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_lvl_q <= 1'b1;
            ones_q     <= '0;
            bitcnt_q   <= '0;
            sr_q       <= '0;
            bytecnt_q  <= '0;
            held_q     <= '0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            se0cnt_q   <= '0;
            jcnt_q     <= '0;
            pkt_q      <= '0;
            ready_q    <= 1'b0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
            store_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            flush_q <= 1'b0;
            store_q <= 1'b0;

            if (samp && is_jk) begin
                prev_lvl_q <= ls_q[1];
            end

            // The run of 1s is tracked only inside a packet. The final 1 of
            // SYNC counts toward the run.
            if (samp) begin
                if (!is_jk || state_q == IDLE || state_q == ERR_WAIT || stuff_slot) begin
                    ones_q <= '0;
                end else if (nrzi_bit) begin
                    ones_q <= ones_q + 3'd1;
                end else begin
                    ones_q <= '0;
                end
            end

            if (err_ev) begin
                state_q  <= ERR_WAIT;
                err_q    <= 1'b1;
                active_q <= 1'b0;
                jcnt_q   <= '0;
            end else if (samp) begin
                case (state_q)
                    IDLE: begin
                        // This first K is the first SYNC bit.
                        if (is_k) begin
                            state_q  <= SYNC;
                            active_q <= 1'b1;
                            err_q    <= 1'b0;
                            bitcnt_q <= 3'd1;
                        end
                    end
                    SYNC: begin
                        if (bit_valid) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= PID;
                            end
                        end
                    end
                    PID: begin
                        if (bit_valid) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            sr_q     <= new_byte;
                        end
                        if (byte_done) begin
                            pkt_q     <= pid_dec;
                            bytecnt_q <= '0;
                            held_q    <= '0;
                            if (pid_dec == 3'd1 || pid_dec == 3'd2) begin
                                state_q <= DATA;
                                flush_q <= 1'b1;
                            end else if (pid_dec >= 3'd6) begin
                                state_q <= TOKEN;
                            end else begin
                                state_q <= HS_EOP;
                            end
                        end
                    end
                    TOKEN: begin
                        if (is_se0) begin
                            state_q  <= EOP;
                            se0cnt_q <= 2'd1;
                        end else if (bit_valid) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (byte_done) begin
                                bytecnt_q <= bytecnt_q + 2'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (is_se0) begin
                            // The two held bytes are the CRC16 and are dropped.
                            state_q  <= EOP;
                            se0cnt_q <= 2'd1;
                        end else if (bit_valid) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            sr_q     <= new_byte;
                            if (byte_done) begin
                                case (held_q)
                                    2'd0: begin
                                        hold0_q <= new_byte;
                                        held_q  <= 2'd1;
                                    end
                                    2'd1: begin
                                        hold1_q <= new_byte;
                                        held_q  <= 2'd2;
                                    end
                                    default: begin
                                        store_q <= 1'b1;
                                        data_q  <= hold0_q;
                                        hold0_q <= hold1_q;
                                        hold1_q <= new_byte;
                                    end
                                endcase
                            end
                        end
                    end
                    HS_EOP: begin
                        if (is_se0) begin
                            state_q  <= EOP;
                            se0cnt_q <= 2'd1;
                        end
                    end
                    EOP: begin
                        if (is_se0) begin
                            se0cnt_q <= se0cnt_q + 2'd1;
                        end else if (is_j) begin
                            state_q  <= IDLE;
                            ready_q  <= 1'b1;
                            active_q <= 1'b0;
                        end
                    end
                    ERR_WAIT: begin
                        if (is_j) begin
                            jcnt_q <= jcnt_q + 3'd1;
                            if (jcnt_q == 3'd7) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            jcnt_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_packet            = pkt_q;
    assign rx_data_ready        = ready_q;
    assign rx_transfer_active   = active_q;
    assign rx_error             = err_q;
    assign flush                = flush_q;
    assign store_rx_packet_data = store_q;
    assign rx_packet_data       = data_q;

endmodule

// File: tb/tb_usb_rx.sv
module tb_usb_rx;

    localparam int unsigned CPB = 4;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic       dplus_in, dminus_in;
    logic [6:0] buffer_occupancy;
    logic [2:0] rx_packet;
    logic       rx_data_ready, rx_transfer_active, rx_error, flush, store_rx_packet_data;
    logic [7:0] rx_packet_data;

    usb_rx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dplus_in            (dplus_in),
        .dminus_in           (dminus_in),
        .buffer_occupancy    (buffer_occupancy),
        .rx_packet           (rx_packet),
        .rx_data_ready       (rx_data_ready),
        .rx_transfer_active  (rx_transfer_active),
        .rx_error            (rx_error),
        .flush               (flush),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data      (rx_packet_data)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // scoreboard: expected stores pushed when stimulus is built; observed by monitor
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_rd = 0;

    // monitor statistics (written only by the monitor)
    int unsigned cyc = 0, flush_cnt = 0, ready_cnt = 0, act_cycles = 0;
    int unsigned err_rises = 0, coincide_cnt = 0, flush_cyc = 0, first_store_cyc = 0;
    int unsigned stores_since_flush = 0;
    logic        err_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (flush === 1'b1) begin
            flush_cnt++;
            flush_cyc = cyc;
            stores_since_flush = 0;
        end
        if (store_rx_packet_data === 1'b1) begin
            obs_q.push_back(rx_packet_data);
            if (stores_since_flush == 0) first_store_cyc = cyc;
            stores_since_flush++;
        end
        if (flush === 1'b1 && store_rx_packet_data === 1'b1) coincide_cnt++;
        if (rx_data_ready === 1'b1) ready_cnt++;
        if (rx_transfer_active === 1'b1) act_cycles++;
        if (rx_error === 1'b1 && err_prev !== 1'b1) err_rises++;
        err_prev = rx_error;
    end

    // baselines for per-packet deltas
    int unsigned b_flush, b_ready, b_act, b_err;

    bit          tx_bits[$];
    int unsigned sent_syms;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_flush = flush_cnt;
        b_ready = ready_cnt;
        b_act   = act_cycles;
        b_err   = err_rises;
        obs_rd  = obs_q.size();
    endtask

    task automatic drive_sym(input logic [1:0] s);
        {dplus_in, dminus_in} = s;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_sym(LS_J);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_bits.push_back(b[i]);
    endtask

    // SYNC is 0000000 then 1 (LSB-first 0x80)
    task automatic start_pkt();
        tx_bits.delete();
        add_byte(8'h80);
    endtask

    // NRZI encode (0 toggles level) starting from J, inserting a stuff 0 after six 1s
    task automatic send_bits(input int limit, input bit stuff_en);
        logic lvl;
        int   ones;
        lvl = 1'b1;
        ones = 0;
        sent_syms = 0;
        for (int i = 0; i < tx_bits.size() && i < limit; i++) begin
            if (!tx_bits[i]) lvl = ~lvl;
            drive_sym(lvl ? LS_J : LS_K);
            sent_syms++;
            ones = tx_bits[i] ? ones + 1 : 0;
            if (stuff_en && ones == 6) begin
                lvl = ~lvl;
                drive_sym(lvl ? LS_J : LS_K);
                sent_syms++;
                ones = 0;
            end
        end
    endtask

    task automatic eop();
        drive_sym(LS_SE0);
        drive_sym(LS_SE0);
        drive_sym(LS_J);
    endtask

    task automatic check_stores(input string tag);
        chk({tag, "_nstores"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                chk({tag, "_store_data"}, 32'(obs_q[obs_rd]), 32'(e));
                obs_rd++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {dplus_in, dminus_in} = LS_J;
        buffer_occupancy = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {17'd0, rx_packet, rx_data_ready, rx_transfer_active, rx_error,
                              flush, store_rx_packet_data, rx_packet_data}, 32'd0);
        @(posedge clk);
        #1;

        // idle bus
        snap();
        idle(20);
        chk("idle_activity", (ready_cnt - b_ready) + (flush_cnt - b_flush) + (act_cycles - b_act), 0);
        chk("idle_stores", 32'(obs_q.size() - obs_rd), 0);
        chk("idle_packet", 32'(rx_packet), 0);
        chk("idle_error", 32'(rx_error), 0);

        // ACK handshake
        snap();
        start_pkt();
        add_byte(8'hD2);
        send_bits(1000, 1'b1);
        eop();
        idle(10);
        chk("ack_pid", 32'(rx_packet), 3);
        chk("ack_ready", ready_cnt - b_ready, 1);
        chk("ack_active_cycles", act_cycles - b_act, (sent_syms + 2) * CPB);
        chk("ack_flush", flush_cnt - b_flush, 0);
        check_stores("ack");
        chk("ack_error", 32'(rx_error), 0);

        // DATA1 with three payload bytes and CRC16
        snap();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h7E);
        start_pkt();
        add_byte(8'h4B);
        add_byte(8'h01);
        add_byte(8'hFF);
        add_byte(8'h7E);
        add_byte(8'hAA);
        add_byte(8'h55);
        send_bits(1000, 1'b1);
        eop();
        idle(10);
        chk("data1_pid", 32'(rx_packet), 2);
        chk("data1_flush", flush_cnt - b_flush, 1);
        check_stores("data1");
        chk("data1_flush_before_store", 32'(first_store_cyc > flush_cyc), 1);
        chk("data1_ready", ready_cnt - b_ready, 1);
        chk("data1_active_cycles", act_cycles - b_act, (sent_syms + 2) * CPB);
        chk("data1_error", 32'(rx_error), 0);

        // OUT token, two bytes
        snap();
        start_pkt();
        add_byte(8'hE1);
        add_byte(8'h81);
        add_byte(8'h3C);
        send_bits(1000, 1'b1);
        eop();
        idle(10);
        chk("out_pid", 32'(rx_packet), 7);
        chk("out_ready", ready_cnt - b_ready, 1);
        chk("out_flush", flush_cnt - b_flush, 0);
        check_stores("out");

        // OUT token, three bytes
        snap();
        start_pkt();
        add_byte(8'hE1);
        add_byte(8'h81);
        add_byte(8'h3C);
        add_byte(8'h00);
        send_bits(1000, 1'b1);
        eop();
        idle(12);
        chk("out3_error_rise", err_rises - b_err, 1);
        chk("out3_error", 32'(rx_error), 1);
        chk("out3_ready", ready_cnt - b_ready, 0);
        chk("out3_active", 32'(rx_transfer_active), 0);

        // PID nibble mismatch
        snap();
        start_pkt();
        add_byte(8'hD3);
        send_bits(1000, 1'b1);
        eop();
        idle(12);
        chk("badpid_error_rise", err_rises - b_err, 1);
        chk("badpid_error", 32'(rx_error), 1);
        chk("badpid_ready", ready_cnt - b_ready, 0);
        chk("badpid_active", 32'(rx_transfer_active), 0);

        // seven consecutive 1s without a stuffed bit
        snap();
        start_pkt();
        add_byte(8'hFF);
        send_bits(1000, 1'b0);
        eop();
        idle(12);
        chk("stuff_error_rise", err_rises - b_err, 1);
        chk("stuff_ready", ready_cnt - b_ready, 0);

        // buffer full at first store
        snap();
        buffer_occupancy = 7'd64;
        start_pkt();
        add_byte(8'hC3);
        add_byte(8'h11);
        add_byte(8'h22);
        add_byte(8'h33);
        add_byte(8'h5A);
        add_byte(8'hA5);
        send_bits(1000, 1'b1);
        eop();
        idle(12);
        chk("ovf_flush", flush_cnt - b_flush, 1);
        check_stores("ovf");
        chk("ovf_error_rise", err_rises - b_err, 1);
        chk("ovf_ready", ready_cnt - b_ready, 0);
        buffer_occupancy = '0;

        // fresh ACK clears the sticky error
        snap();
        start_pkt();
        add_byte(8'hD2);
        send_bits(1000, 1'b1);
        eop();
        idle(10);
        chk("recover_error", 32'(rx_error), 0);
        chk("recover_ready", ready_cnt - b_ready, 1);
        chk("recover_pid", 32'(rx_packet), 3);

        // occupancy one below the limit still stores
        snap();
        buffer_occupancy = 7'd63;
        exp_q.push_back(8'h99);
        start_pkt();
        add_byte(8'hC3);
        add_byte(8'h99);
        add_byte(8'h12);
        add_byte(8'h34);
        send_bits(1000, 1'b1);
        eop();
        idle(10);
        check_stores("occ63");
        chk("occ63_ready", ready_cnt - b_ready, 1);
        chk("occ63_pid", 32'(rx_packet), 1);
        chk("occ63_error", 32'(rx_error), 0);
        buffer_occupancy = '0;

        // reset in the middle of payload byte 2 of a DATA0 packet
        snap();
        start_pkt();
        add_byte(8'hC3);
        add_byte(8'h10);
        add_byte(8'h20);
        send_bits(28, 1'b1);
        @(negedge clk);
        chk("midrst_active_before", 32'(rx_transfer_active), 1);
        chk("midrst_pid_before", 32'(rx_packet), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        {dplus_in, dminus_in} = LS_J;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {17'd0, rx_packet, rx_data_ready, rx_transfer_active, rx_error,
                               flush, store_rx_packet_data, rx_packet_data}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        snap();
        idle(20);
        chk("midrst_ready", ready_cnt - b_ready, 0);
        chk("midrst_error_rise", err_rises - b_err, 0);
        chk("midrst_error", 32'(rx_error), 0);

        // NAK after reset
        snap();
        start_pkt();
        add_byte(8'h5A);
        send_bits(1000, 1'b1);
        eop();
        idle(10);
        chk("nak_pid", 32'(rx_packet), 4);
        chk("nak_ready", ready_cnt - b_ready, 1);
        chk("nak_error", 32'(rx_error), 0);

        chk("flush_store_overlap", coincide_cnt, 0);
        chk("scoreboard_leftover", 32'(obs_q.size() - obs_rd), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
